// File: rtl/clk_gen_pkg.sv
// Shared constants for the multi-rate frame clock generator.
// Rate index to name:
//   0 : 30 Hz  (HALF_0 = 1666666 cycles of 100 MHz per half-period)
//   1 : 40 Hz  (HALF_1 = 1250000)
//   2 : 50 Hz  (HALF_2 = 1000000)
//   3 : 60 Hz  (HALF_3 =  833333)
package clk_gen_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int RATE_W = 2;

    localparam int HALF_0 = 1666666;
    localparam int HALF_1 = 1250000;
    localparam int HALF_2 = 1000000;
    localparam int HALF_3 = 833333;

    typedef enum logic [RATE_W-1:0] {
        RATE_30HZ = 2'd0,
        RATE_40HZ = 2'd1,
        RATE_50HZ = 2'd2,
        RATE_60HZ = 2'd3
    } rate_e;

endpackage

// File: rtl/rate_clock_channel.sv
// One divided-clock channel.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low holds the channel at phase 0
//   select       requested rate index
//   sync_req     restart pulse shared by all channels
//   clk_div      registered 50 % duty divided clock
//   tick         one-cycle strobe on the cycle clk_div rises
//   rate_pending combinational: select differs from the committed rate
module rate_clock_channel
    import clk_gen_pkg::*;
#(
    parameter int CTR_W  = 22,
    parameter int HALF_0 = clk_gen_pkg::HALF_0,
    parameter int HALF_1 = clk_gen_pkg::HALF_1,
    parameter int HALF_2 = clk_gen_pkg::HALF_2,
    parameter int HALF_3 = clk_gen_pkg::HALF_3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RATE_W-1:0] select,
    input  logic              sync_req,
    output logic              clk_div,
    output logic              tick,
    output logic              rate_pending
);

    localparam logic [CTR_W-1:0] HM1_0 = CTR_W'(HALF_0 - 1);
    localparam logic [CTR_W-1:0] HM1_1 = CTR_W'(HALF_1 - 1);
    localparam logic [CTR_W-1:0] HM1_2 = CTR_W'(HALF_2 - 1);
    localparam logic [CTR_W-1:0] HM1_3 = CTR_W'(HALF_3 - 1);

    // Terminal count (half-period minus one) for a given rate index.
    function automatic logic [CTR_W-1:0] term_count(input logic [RATE_W-1:0] rate);
        logic [CTR_W-1:0] tc;
        case (rate)
            RATE_30HZ: tc = HM1_0;
            RATE_40HZ: tc = HM1_1;
            RATE_50HZ: tc = HM1_2;
            RATE_60HZ: tc = HM1_3;
            default:   tc = HM1_0;
        endcase
        return tc;
    endfunction

    logic [CTR_W-1:0]  ctr_q,     ctr_d;
    logic [RATE_W-1:0] cur_q,     cur_d;
    logic              clk_div_q, clk_div_d;
    logic              tick_q,    tick_d;
    logic              terminal_s;

    assign terminal_s   = (ctr_q == term_count(cur_q));
    assign rate_pending = (select != cur_q);
    assign clk_div      = clk_div_q;
    assign tick         = tick_q;

    // Next-state: sync, then disable, then terminal count, then count.
    // The committed rate only moves at a half-period boundary or while
    // the channel is parked, so a half-period in flight is never altered.
    always_comb begin
        ctr_d     = ctr_q;
        cur_d     = cur_q;
        clk_div_d = clk_div_q;
        tick_d    = 1'b0;
        if (sync_req || !en) begin
            ctr_d     = {CTR_W{1'b0}};
            clk_div_d = 1'b0;
            tick_d    = 1'b0;
            cur_d     = select;
        end else if (terminal_s) begin
            ctr_d     = {CTR_W{1'b0}};
            clk_div_d = ~clk_div_q;
            tick_d    = ~clk_div_q;
            cur_d     = select;
        end else begin
            ctr_d     = ctr_q + {{(CTR_W-1){1'b0}}, 1'b1};
            tick_d    = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q     <= {CTR_W{1'b0}};
            cur_q     <= {RATE_W{1'b0}};
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            cur_q     <= cur_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

endmodule

// File: rtl/multi_rate_clock_gen.sv
// Multi-channel frame clock generator: CHANNELS independent divided clocks
// from the 100 MHz system clock, each at 30/40/50/60 Hz.
// Ports:
//   clk_100MHz   system clock
//   rst_n        asynchronous active-low reset
//   en           per-channel run enable
//   select       per-channel rate index, channel i in bits [2i+1:2i]
//   sync_req     one-cycle pulse restarting all channels in phase
//   clk_div      per-channel divided clocks
//   tick         per-channel rise strobes
//   rate_pending per-channel uncommitted rate change indicator
module multi_rate_clock_gen
    import clk_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CTR_W    = 22,
    parameter int HALF_0   = clk_gen_pkg::HALF_0,
    parameter int HALF_1   = clk_gen_pkg::HALF_1,
    parameter int HALF_2   = clk_gen_pkg::HALF_2,
    parameter int HALF_3   = clk_gen_pkg::HALF_3
) (
    input  logic                         clk_100MHz,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          en,
    input  logic [RATE_W*CHANNELS-1:0]   select,
    input  logic                         sync_req,
    output logic [CHANNELS-1:0]          clk_div,
    output logic [CHANNELS-1:0]          tick,
    output logic [CHANNELS-1:0]          rate_pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rate_clock_channel #(
            .CTR_W  (CTR_W),
            .HALF_0 (HALF_0),
            .HALF_1 (HALF_1),
            .HALF_2 (HALF_2),
            .HALF_3 (HALF_3)
        ) u_ch (
            .clk          (clk_100MHz),
            .rst_n        (rst_n),
            .en           (en[i]),
            .select       (select[RATE_W*i +: RATE_W]),
            .sync_req     (sync_req),
            .clk_div      (clk_div[i]),
            .tick         (tick[i]),
            .rate_pending (rate_pending[i])
        );
    end

endmodule

// File: tb/tb_multi_rate_clock_gen.sv
module tb_multi_rate_clock_gen;

    logic       clk_100MHz = 1'b0;
    logic       rst_n      = 1'b0;
    logic [1:0] en         = 2'b00;
    logic [3:0] select     = 4'b0000;
    logic       sync_req   = 1'b0;
    logic [1:0] clk_div;
    logic [1:0] tick;
    logic [1:0] rate_pending;

    int n_vec = 0;
    int n_err = 0;

    multi_rate_clock_gen #(
        .CHANNELS (2),
        .CTR_W    (4),
        .HALF_0   (6),
        .HALF_1   (5),
        .HALF_2   (4),
        .HALF_3   (3)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .rst_n        (rst_n),
        .en           (en),
        .select       (select),
        .sync_req     (sync_req),
        .clk_div      (clk_div),
        .tick         (tick),
        .rate_pending (rate_pending)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    // Steps until clk_div[ch] is high; n = edges taken, -1 on timeout.
    task automatic wait_rise(input int ch, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (clk_div[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) step();
        n_vec++;
        if (clk_div !== 2'b00 || tick !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state: clk_div=%b tick=%b required 00/00", clk_div, tick);
        end
        n_vec++;
        if (rate_pending !== 2'b00) begin
            n_err++;
            $display("FAIL reset_pending: got %b required 00", rate_pending);
        end
        rst_n = 1'b1;
        en    = 2'b01;
        wait_rise(0, n);
        n_vec++;
        if (n !== 6) begin
            n_err++;
            $display("FAIL first_rise: edges=%0d required 6", n);
        end
        n_vec++;
        if (tick !== 2'b01) begin
            n_err++;
            $display("FAIL first_tick: got %b required 01", tick);
        end
        // Asynchronous reset while clk_div is high.
        #2;
        rst_n  = 1'b0;
        select = 4'b0010;
        #1;
        n_vec++;
        if (clk_div !== 2'b00 || tick !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset: clk_div=%b tick=%b required 00/00", clk_div, tick);
        end
        n_vec++;
        if (rate_pending !== 2'b01) begin
            n_err++;
            $display("FAIL reset_pending_sel: got %b required 01", rate_pending);
        end
        select = 4'b0000;
        #1;
        rst_n = 1'b1;
        wait_rise(0, n);
        n_vec++;
        if (n !== 6) begin
            n_err++;
            $display("FAIL rise_after_release: edges=%0d required 6", n);
        end
    endtask

    // Starts just after a rise of ch0 at rate 0.
    task automatic test_steady_rate();
        logic exp_clk;
        logic exp_tick;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_clk  = (k < 6 || k == 12) ? 1'b1 : 1'b0;
            exp_tick = (k == 12) ? 1'b1 : 1'b0;
            n_vec++;
            if (clk_div[0] !== exp_clk || tick[0] !== exp_tick) begin
                n_err++;
                $display("FAIL steady k=%0d: clk_div=%b tick=%b required %b/%b",
                         k, clk_div[0], tick[0], exp_clk, exp_tick);
            end
        end
    endtask

    // Starts just after a rise of ch0 at rate 0.
    task automatic test_mid_change();
        logic exp_clk;
        logic exp_pend;
        repeat (2) step();
        select[1:0] = 2'd3;
        #1;
        n_vec++;
        if (rate_pending[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pending_set: got %b required 1", rate_pending[0]);
        end
        for (int k = 3; k <= 15; k++) begin
            step();
            exp_pend = (k < 6) ? 1'b1 : 1'b0;
            exp_clk  = (k < 6 || (k >= 9 && k < 12) || k >= 15) ? 1'b1 : 1'b0;
            n_vec++;
            if (clk_div[0] !== exp_clk || rate_pending[0] !== exp_pend) begin
                n_err++;
                $display("FAIL mid_change k=%0d: clk_div=%b pend=%b required %b/%b",
                         k, clk_div[0], rate_pending[0], exp_clk, exp_pend);
            end
            if (k == 9 || k == 15) begin
                n_vec++;
                if (tick[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL mid_tick k=%0d: got %b required 1", k, tick[0]);
                end
            end
        end
    endtask

    task automatic test_aborted_change();
        int   n;
        logic exp_clk;
        en[0]       = 1'b0;
        select[1:0] = 2'd0;
        step();
        en[0] = 1'b1;
        wait_rise(0, n);
        n_vec++;
        if (n !== 6) begin
            n_err++;
            $display("FAIL abort_restart: edges=%0d required 6", n);
        end
        step();
        select[1:0] = 2'd2;
        #1;
        n_vec++;
        if (rate_pending[0] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pending_set: got %b required 1", rate_pending[0]);
        end
        step();
        select[1:0] = 2'd0;
        #1;
        n_vec++;
        if (rate_pending[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pending_clear: got %b required 0", rate_pending[0]);
        end
        for (int k = 3; k <= 12; k++) begin
            step();
            exp_clk = (k < 6 || k == 12) ? 1'b1 : 1'b0;
            n_vec++;
            if (clk_div[0] !== exp_clk) begin
                n_err++;
                $display("FAIL abort_period k=%0d: got %b required %b", k, clk_div[0], exp_clk);
            end
        end
    endtask

    task automatic test_sync();
        logic [1:0] exp_clk;
        en     = 2'b00;
        select = 4'b0101;
        step();
        en = 2'b01;
        repeat (3) step();
        en = 2'b11;
        repeat (2) step();
        n_vec++;
        if (clk_div !== 2'b01) begin
            n_err++;
            $display("FAIL sync_skew: clk_div=%b required 01", clk_div);
        end
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        n_vec++;
        if (clk_div !== 2'b00 || tick !== 2'b00) begin
            n_err++;
            $display("FAIL sync_cycle: clk_div=%b tick=%b required 00/00", clk_div, tick);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_clk = (k == 5) ? 2'b11 : 2'b00;
            n_vec++;
            if (clk_div !== exp_clk || tick !== exp_clk) begin
                n_err++;
                $display("FAIL sync_align k=%0d: clk_div=%b tick=%b required %b/%b",
                         k, clk_div, tick, exp_clk, exp_clk);
            end
        end
    endtask

    // Starts with both channels just risen at rate 1.
    task automatic test_disable();
        int n;
        en     = 2'b01;
        select = 4'b1101;
        #1;
        n_vec++;
        if (rate_pending !== 2'b10) begin
            n_err++;
            $display("FAIL dis_pending_set: got %b required 10", rate_pending);
        end
        step();
        n_vec++;
        if (clk_div[1] !== 1'b0 || tick[1] !== 1'b0) begin
            n_err++;
            $display("FAIL dis_fall: clk_div=%b tick=%b required 0/0", clk_div[1], tick[1]);
        end
        n_vec++;
        if (rate_pending !== 2'b00 || clk_div[0] !== 1'b1) begin
            n_err++;
            $display("FAIL dis_commit: pend=%b clk_div0=%b required 00/1",
                     rate_pending, clk_div[0]);
        end
        en = 2'b11;
        wait_rise(1, n);
        n_vec++;
        if (n !== 3 || tick[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reenable_rise: edges=%0d tick=%b required 3/1", n, tick[1]);
        end
    endtask

    initial begin
        test_reset();
        test_steady_rate();
        test_mid_change();
        test_aborted_change();
        test_sync();
        test_disable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_rate_clock_gen.md
# multi_rate_clock_gen

Multi-channel successor to the single-output frame-rate divider. It derives CHANNELS independent slow clocks from the 100 MHz system clock, each running at one of four preset rates: 30, 40, 50 or 60 Hz. Each channel has its own enable and rate select. Rate changes are committed only at a half-period boundary, so no runt pulses occur. A one-cycle tick strobe is produced on every rising edge of each divided clock, and a global sync pulse phase-aligns all channels. It feeds the display/game-logic frame timing.

## Interface
- CHANNELS, 4, number of independent output channels
- CTR_W, 22, half-period counter width; must hold the largest HALF_x − 1
- HALF_0, 1666666, half-period in cycles for rate 0 (30 Hz)
- HALF_1, 1250000, half-period in cycles for rate 1 (40 Hz)
- HALF_2, 1000000, half-period in cycles for rate 2 (50 Hz)
- HALF_3, 833333, half-period in cycles for rate 3 (60 Hz)
- clk_100MHz  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  CHANNELS  per-channel run enable
- select  in  2*CHANNELS  per-channel rate index; channel i uses bits [2i+1:2i]
- sync_req  in  1  one-cycle pulse that restarts all channels in phase
- clk_div  out  CHANNELS  divided clocks, registered, 50 % duty
- tick  out  CHANNELS  one-cycle strobe, high on the cycle clk_div[i] rises
- rate_pending  out  CHANNELS  combinational; high while select[i] ≠ committed rate of channel i

## Operation
- Per-channel state: ctr (CTR_W bits), committed rate cur (2 bits), clk_div, tick. H = HALF_cur.
- Reset (rst_n low) asynchronously clears ctr, cur, clk_div and tick to 0 on all channels. rate_pending then reflects select ≠ 0.
- Per-channel priority each edge, highest first: sync_req, then en low, then terminal count, then count.
  - sync_req high: ctr←0, clk_div←0, tick←0, cur←select. Applies to all channels, including disabled ones.
  - en[i] low: ctr←0, clk_div←0, tick←0, cur←select. Rate changes take effect immediately while disabled.
  - en[i] high and ctr = H−1: ctr←0, clk_div←~clk_div, cur←select (commit point). tick←1 if clk_div was 0, else 0.
  - en[i] high and ctr ≠ H−1: ctr←ctr+1, tick←0; cur is held.
- A select change mid-half-period never truncates or stretches the half-period in progress. The new H applies from the next half-period.
- If select returns to the committed value before the boundary, nothing changes and rate_pending drops.
- Channels are fully independent except for sync_req.

## Timing
- Counting starts on the first edge with en high: ctr goes 0→1.
- clk_div first rises on the H-th enabled edge. Period is 2H cycles, with H cycles high and H cycles low.
- tick is asserted on the same edge that clk_div goes 0→1 and lasts exactly one cycle. There are no ticks while disabled or in the sync cycle.
- Rate change latency: the committed rate updates at the next terminal count; worst case is H_old cycles.
- After sync_req, all channels enabled in that cycle rise on the same edge if they share a rate.
- en deasserted while clk_div is high: clk_div falls on the next edge, no tick.
- rst_n deasserted mid-count: outputs are 0 with no clock edge required. Counting resumes from 0 after release.

## Structure
- Package clk_gen_pkg holds:
  - CLK_HZ = 100_000_000
  - default HALF_0..HALF_3 constants, plus a rate-index-to-name comment list
  - RATE_W = 2
- Sub-module rate_clock_channel, one per channel via generate. Ports: clk, rst_n, en, select[1:0], sync_req, the four half-periods as parameters, clk_div, tick, rate_pending.
- Top level only slices the vectors and fans out sync_req.

## Test plan
Bench overrides HALF_0..3 = 6, 5, 4, 3 and uses CHANNELS = 2.
- Reset: rst_n low mid-run with clk_div = 1 → clk_div, tick and ctr go 0 before the next edge. After release with en = 1 and select = 0, the first rise occurs 6 edges later.
- Steady rate: ch0 en = 1, select = 0 → clk_div period 12 cycles, high for 6. tick pulses once every 12 cycles, aligned with the rise.
- Mid-half change: select 0→3 at ctr = 2 → rate_pending = 1 for 4 cycles. The current half lasts 6 cycles and subsequent halves last 3 (period 6).
- Aborted change: select 0→2→0 within one half-period → period stays 12, and rate_pending pulses then returns to 0.
- Sync: ch0 and ch1 both at rate 1 but 3 cycles out of phase; sync_req pulse → both clk_div = 0, then both rise on the same edge 5 cycles later.
- Disable: en[1] drops while clk_div[1] = 1 → clk_div[1] = 0 next edge, no tick. Re-enable with select = 3 → first rise after 3 edges.
